// File: rtl/sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_scheduler
// Description : Moves mock readout data through SDRAM, which is used as a
//               ring buffer. Fixed-length write bursts drain the 32-bit data
//               FIFO into SDRAM, and fixed-length read bursts are scheduled
//               toward the host pipe-out FIFO. When both directions are
//               eligible, the grant alternates between write and read.
//               Runs in the data-FIFO read-clock domain.
// Ports       :
//   CLK, RST             clock, asynchronous active-high reset
//   enable               permits new write bursts
//   clr_status           clears the sticky overflow flag
//   fifo_rd_data_count   data-FIFO occupancy
//   fifo_rd              data-FIFO read enable
//   fifo_dout            data-FIFO output word
//   fifo_dout_valid      data-FIFO output valid, one cycle after fifo_rd
//   wr_cmd_req/ack       SDRAM write-burst command handshake
//   wr_addr              write-burst start address
//   wr_data/wr_data_en   write data beats to SDRAM
//   wr_done              write burst committed (1-cycle pulse)
//   rd_space             free words in the host pipe-out FIFO
//   rd_cmd_req/ack       SDRAM read-burst command handshake
//   rd_addr              read-burst start address
//   rd_done              read burst delivered (1-cycle pulse)
//   fill_words           words currently held in the ring
//   overflow             sticky: data FIFO near full while writes are blocked
//   busy                 scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_scheduler #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 22,
  parameter int HIGH_WM   = 240
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clr_status,
  input  logic [7:0]        fifo_rd_data_count,
  output logic              fifo_rd,
  input  logic [31:0]       fifo_dout,
  input  logic              fifo_dout_valid,
  output logic              wr_cmd_req,
  input  logic              wr_cmd_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_data_en,
  input  logic              wr_done,
  input  logic [7:0]        rd_space,
  output logic              rd_cmd_req,
  input  logic              rd_cmd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [ADDR_W:0]   fill_words,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W  = $clog2(BURST_LEN) + 1;
  localparam int FILL_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  BL_CNT      = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BL_CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BL_ADDR     = ADDR_W'(BURST_LEN);
  localparam logic [FILL_W-1:0] BL_FILL     = FILL_W'(BURST_LEN);
  // Highest fill level that still leaves room for one more whole burst.
  localparam logic [FILL_W-1:0] WR_FILL_MAX = FILL_W'((2 ** ADDR_W) - BURST_LEN);
  localparam logic [7:0]        BL_LVL      = 8'(BURST_LEN);
  localparam logic [7:0]        HIGH_WM_LVL = 8'(HIGH_WM);

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_XFER = 3'd2,
    WR_WAIT = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic              done_pending;

  logic              wr_elig;
  logic              rd_elig;
  logic              grant_wr;
  logic              grant_rd;
  logic              wr_commit;
  logic              rd_commit;
  logic              overflow_set;

  assign wr_elig = enable
                 & (fifo_rd_data_count >= BL_LVL)
                 & (fill_words <= WR_FILL_MAX);
  assign rd_elig = (fill_words >= BL_FILL) & (rd_space >= BL_LVL);

  assign overflow_set = (state == IDLE) & enable
                      & (fifo_rd_data_count >= HIGH_WM_LVL) & ~wr_elig;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    wr_commit  = 1'b0;
    rd_commit  = 1'b0;
    wr_cmd_req = 1'b0;
    rd_cmd_req = 1'b0;
    fifo_rd    = 1'b0;
    wr_data    = '0;
    wr_data_en = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // A tie goes to the side that did not win last time.
        if (wr_elig && (!rd_elig || last_grant == GRANT_RD)) begin
          grant_wr   = 1'b1;
          state_next = WR_REQ;
        end else if (rd_elig) begin
          grant_rd   = 1'b1;
          state_next = RD_REQ;
        end
      end

      WR_REQ: begin
        wr_cmd_req = 1'b1;
        if (wr_cmd_ack) begin
          state_next = WR_XFER;
        end
      end

      WR_XFER: begin
        fifo_rd    = (issue_cnt < BL_CNT);
        wr_data    = fifo_dout;
        wr_data_en = fifo_dout_valid;
        if (fifo_dout_valid && rx_cnt == BL_CNT_LAST) begin
          // A commit that overtook the data is applied here directly.
          if (done_pending || wr_done) begin
            wr_commit  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WR_WAIT;
          end
        end
      end

      WR_WAIT: begin
        if (wr_done) begin
          wr_commit  = 1'b1;
          state_next = IDLE;
        end
      end

      RD_REQ: begin
        rd_cmd_req = 1'b1;
        if (rd_cmd_ack) begin
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (rd_done) begin
          rd_commit  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst counters, ring pointers, fill level and status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant   <= GRANT_RD;
      issue_cnt    <= '0;
      rx_cnt       <= '0;
      done_pending <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      fill_words   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (grant_wr) begin
        last_grant <= GRANT_WR;
      end else if (grant_rd) begin
        last_grant <= GRANT_RD;
      end

      // Counters are primed while the command waits for acceptance.
      if (state == WR_REQ) begin
        issue_cnt    <= '0;
        rx_cnt       <= '0;
        done_pending <= 1'b0;
      end else if (state == WR_XFER) begin
        if (fifo_rd) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (fifo_dout_valid) begin
          rx_cnt <= rx_cnt + 1'b1;
        end
        if (wr_done) begin
          done_pending <= 1'b1;
        end
      end

      // Commits are state-exclusive, so only one fill update per cycle.
      // Pointer addition wraps naturally at the ring size.
      if (wr_commit) begin
        wr_addr    <= wr_addr + BL_ADDR;
        fill_words <= fill_words + BL_FILL;
      end else if (rd_commit) begin
        rd_addr    <= rd_addr + BL_ADDR;
        fill_words <= fill_words - BL_FILL;
      end

      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_burst_scheduler
// Description : Scoreboard bench for sdram_burst_scheduler (ADDR_W=8,
//               BURST_LEN=16). Directed steps push expected commands and
//               data beats into a queue; a monitor pops and compares them as
//               the DUT presents them. Simple SDRAM-controller and data-FIFO
//               models answer the DUT handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_scheduler;

  localparam int BL     = 16;
  localparam int AW     = 8;
  localparam int HWM    = 240;
  localparam logic [31:0] WORD_BASE = 32'hC0DE_0000;

  localparam logic [1:0] K_WCMD = 2'd0;
  localparam logic [1:0] K_RCMD = 2'd1;
  localparam logic [1:0] K_DATA = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enable = 1'b0;
  logic          clr_status = 1'b0;
  logic [7:0]    fifo_rd_data_count = 8'd0;
  logic          fifo_rd;
  logic [31:0]   fifo_dout;
  logic          fifo_dout_valid;
  logic          wr_cmd_req;
  logic          wr_cmd_ack;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_data_en;
  logic          wr_done;
  logic [7:0]    rd_space = 8'd0;
  logic          rd_cmd_req;
  logic          rd_cmd_ack;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic [AW:0]   fill_words;
  logic          overflow;
  logic          busy;

  logic wr_ack_r = 1'b0, wr_done_r = 1'b0, rd_ack_r = 1'b0, rd_done_r = 1'b0;
  logic spur_wr_ack = 1'b0, spur_wr_done = 1'b0, spur_rd_done = 1'b0;
  assign wr_cmd_ack = wr_ack_r | spur_wr_ack;
  assign wr_done    = wr_done_r | spur_wr_done;
  assign rd_cmd_ack = rd_ack_r;
  assign rd_done    = rd_done_r | spur_rd_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  int   exp_word = 0;
  bit   mon_data_en = 1'b1;
  int   rd_pulses = 0;
  int   wr_reqs = 0;
  int   rd_reqs = 0;

  sdram_burst_scheduler #(.BURST_LEN(BL), .ADDR_W(AW), .HIGH_WM(HWM)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .clr_status(clr_status),
    .fifo_rd_data_count(fifo_rd_data_count), .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout), .fifo_dout_valid(fifo_dout_valid),
    .wr_cmd_req(wr_cmd_req), .wr_cmd_ack(wr_cmd_ack), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_data_en(wr_data_en), .wr_done(wr_done),
    .rd_space(rd_space), .rd_cmd_req(rd_cmd_req), .rd_cmd_ack(rd_cmd_ack),
    .rd_addr(rd_addr), .rd_done(rd_done), .fill_words(fill_words),
    .overflow(overflow), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Data FIFO model: word n of the stream is WORD_BASE + n, one-cycle latency.
  logic [31:0] word_idx;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_dout_valid <= 1'b0;
      fifo_dout       <= '0;
      word_idx        <= '0;
    end else begin
      fifo_dout_valid <= fifo_rd;
      if (fifo_rd) begin
        fifo_dout <= WORD_BASE + word_idx;
        word_idx  <= word_idx + 32'd1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM controller model: write ack after 2 cycles, done 3 cycles after the
  // 16th beat; read ack after 2 cycles, done 4 cycles later.
  initial begin
    int wph = 0, wcnt = 0, wbeats = 0, rph = 0, rcnt = 0;
    forever begin
      @(negedge CLK);
      wr_ack_r = 1'b0; wr_done_r = 1'b0; rd_ack_r = 1'b0; rd_done_r = 1'b0;
      if (RST) begin
        wph = 0; rph = 0;
      end else begin
        case (wph)
          0: if (wr_cmd_req) begin wcnt = 2; wph = 1; end
          1: begin
            wcnt--;
            if (wcnt == 0) begin wr_ack_r = 1'b1; wph = 2; wbeats = 0; end
          end
          2: if (wr_data_en) begin
            wbeats++;
            if (wbeats == BL) begin wcnt = 3; wph = 3; end
          end
          default: begin
            wcnt--;
            if (wcnt == 0) begin wr_done_r = 1'b1; wph = 0; end
          end
        endcase
        case (rph)
          0: if (rd_cmd_req) begin rcnt = 2; rph = 1; end
          1: begin
            rcnt--;
            if (rcnt == 0) begin rd_ack_r = 1'b1; rcnt = 4; rph = 2; end
          end
          default: begin
            rcnt--;
            if (rcnt == 0) begin rd_done_r = 1'b1; rph = 0; end
          end
        endcase
      end
    end
  end

  // Monitor: pops one expectation per command rise or data beat.
  initial begin
    logic prev_w = 1'b0, prev_r = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_w = 1'b0; prev_r = 1'b0;
      end else begin
        if (fifo_rd) rd_pulses++;
        if (wr_cmd_req && !prev_w) begin
          wr_reqs++;
          if (sb_q.size() == 0) check("unexpected write cmd", {32'd0, 24'd0, wr_addr}, 64'hDEAD);
          else begin e = sb_q.pop_front(); check("write cmd", {30'd0, K_WCMD, 24'd0, wr_addr}, {30'd0, e.kind, e.val}); end
        end
        if (rd_cmd_req && !prev_r) begin
          rd_reqs++;
          if (sb_q.size() == 0) check("unexpected read cmd", {32'd0, 24'd0, rd_addr}, 64'hDEAD);
          else begin e = sb_q.pop_front(); check("read cmd", {30'd0, K_RCMD, 24'd0, rd_addr}, {30'd0, e.kind, e.val}); end
        end
        if (wr_data_en && mon_data_en) begin
          if (sb_q.size() == 0) check("unexpected data beat", {32'd0, wr_data}, 64'hDEAD);
          else begin e = sb_q.pop_front(); check("data beat", {30'd0, K_DATA, wr_data}, {30'd0, e.kind, e.val}); end
        end
        prev_w = wr_cmd_req;
        prev_r = rd_cmd_req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input int addr);
    sb_q.push_back('{kind: K_WCMD, val: 32'(addr)});
    for (int i = 0; i < BL; i++) begin
      sb_q.push_back('{kind: K_DATA, val: WORD_BASE + 32'(exp_word)});
      exp_word++;
    end
  endtask

  task automatic push_rd(input int addr);
    sb_q.push_back('{kind: K_RCMD, val: 32'(addr)});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_for(input int which, input string name);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 500) begin
      @(negedge CLK); #1;
      case (which)
        0: hit = wr_cmd_req;
        1: hit = rd_cmd_req;
        default: hit = fifo_rd;
      endcase
      n++;
    end
    if (!hit) check({name, " wait timeout"}, 64'd0, 64'd1);
  endtask

  task automatic settle(input string name);
    int n = 0, quiet = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge CLK); #1;
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    if (quiet < 4) check({name, " settle timeout"}, 64'd0, 64'd1);
  endtask

  task automatic single_write(input int addr, input string name);
    push_wr(addr);
    fifo_rd_data_count = 8'd16;
    wait_for(0, name);
    fifo_rd_data_count = 8'd0;
    settle(name);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycles(3);
    RST = 1'b0;
    exp_word = 0;
    cycles(1);
  endtask

  initial begin
    int base;
    do_reset();

    // Reset state
    check("reset fill", 64'(fill_words), 64'd0);
    check("reset wr_addr", 64'(wr_addr), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'd0);
    check("reset strobes", 64'({wr_cmd_req, rd_cmd_req, fifo_rd, wr_data_en, busy, overflow}), 64'd0);

    // Single write
    enable = 1'b1;
    base = rd_pulses;
    single_write(0, "single write");
    check("single fifo_rd count", 64'(rd_pulses - base), 64'd16);
    check("single wr_addr", 64'(wr_addr), 64'd16);
    check("single fill", 64'(fill_words), 64'd16);

    // Two more writes, then read gating at rd_space 15 / 16
    single_write(16, "write 2");
    single_write(32, "write 3");
    check("fill before read", 64'(fill_words), 64'd48);
    base = rd_reqs;
    rd_space = 8'd15;
    cycles(30);
    check("no read at rd_space 15", 64'(rd_reqs - base), 64'd0);
    push_rd(0);
    rd_space = 8'd16;
    wait_for(1, "read gating");
    rd_space = 8'd0;
    settle("read gating");
    check("read rd_addr", 64'(rd_addr), 64'd16);
    check("read fill", 64'(fill_words), 64'd32);

    // Round-robin: last grant was a read, so the order is W,R,W,R
    push_wr(48); push_rd(16); push_wr(64); push_rd(32);
    base = wr_reqs + rd_reqs;
    fifo_rd_data_count = 8'd200;
    rd_space = 8'd64;
    for (int n = 0; n < 400 && (wr_reqs + rd_reqs) < base + 4; n++) cycles(1);
    fifo_rd_data_count = 8'd0;
    rd_space = 8'd0;
    settle("round robin");
    check("rr grants", 64'(wr_reqs + rd_reqs - base), 64'd4);
    check("rr wr_addr", 64'(wr_addr), 64'd80);
    check("rr rd_addr", 64'(rd_addr), 64'd48);
    check("rr fill", 64'(fill_words), 64'd32);

    // Reset in the middle of a write burst, at the 5th fifo_rd
    mon_data_en = 1'b0;
    sb_q.push_back('{kind: K_WCMD, val: 32'd80});
    base = rd_pulses;
    fifo_rd_data_count = 8'd16;
    for (int n = 0; n < 200 && rd_pulses < base + 5; n++) cycles(1);
    check("mid-burst fifo_rd reached", 64'(rd_pulses - base), 64'd5);
    RST = 1'b1;
    fifo_rd_data_count = 8'd0;
    #1;
    check("async reset strobes", 64'({wr_cmd_req, rd_cmd_req, fifo_rd, wr_data_en, busy, overflow}), 64'd0);
    check("async reset fill", 64'(fill_words), 64'd0);
    check("async reset wr_addr", 64'(wr_addr), 64'd0);
    cycles(2);
    RST = 1'b0;
    exp_word = 0;
    mon_data_en = 1'b1;
    cycles(1);
    single_write(0, "post-reset write");
    check("post-reset wr_addr", 64'(wr_addr), 64'd16);
    check("post-reset fill", 64'(fill_words), 64'd16);

    // enable drops during WR_XFER: the burst completes, no new writes
    push_wr(16);
    base = rd_pulses;
    fifo_rd_data_count = 8'd16;
    wait_for(2, "enable drop");
    enable = 1'b0;
    fifo_rd_data_count = 8'd200;
    settle("enable drop");
    check("enable drop fifo_rd count", 64'(rd_pulses - base), 64'd16);
    check("enable drop fill", 64'(fill_words), 64'd32);
    base = wr_reqs;
    cycles(40);
    check("no write while disabled", 64'(wr_reqs - base), 64'd0);
    push_rd(0); push_rd(16);
    rd_space = 8'd64;
    wait_for(1, "drain");
    settle("drain");
    rd_space = 8'd0;
    check("drain fill", 64'(fill_words), 64'd0);
    check("drain rd_addr", 64'(rd_addr), 64'd32);
    check("no overflow while disabled", 64'(overflow), 64'd0);

    // Wrap / full: 16 writes, no reads
    fifo_rd_data_count = 8'd0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) push_wr(i * BL);
    base = wr_reqs;
    fifo_rd_data_count = 8'd200;
    wait_for(0, "fill ring");
    settle("fill ring");
    check("full fill", 64'(fill_words), 64'd256);
    check("full wr_addr wrapped", 64'(wr_addr), 64'd0);
    cycles(30);
    check("writes blocked when full", 64'(wr_reqs - base), 64'd16);
    check("no overflow below mark", 64'(overflow), 64'd0);

    // Stray handshakes while idle are ignored
    spur_wr_ack = 1'b1; spur_wr_done = 1'b1; spur_rd_done = 1'b1;
    cycles(1);
    spur_wr_ack = 1'b0; spur_wr_done = 1'b0; spur_rd_done = 1'b0;
    cycles(2);
    check("stray pulses fill", 64'(fill_words), 64'd256);
    check("stray pulses pointers", 64'({wr_addr, rd_addr}), 64'd0);

    fifo_rd_data_count = 8'd240;
    cycles(2);
    check("overflow set", 64'(overflow), 64'd1);
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    check("overflow set beats clear", 64'(overflow), 64'd1);
    fifo_rd_data_count = 8'd100;
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    check("overflow cleared", 64'(overflow), 64'd0);
    fifo_rd_data_count = 8'd239;
    cycles(3);
    check("no overflow at 239", 64'(overflow), 64'd0);
    enable = 1'b0;
    fifo_rd_data_count = 8'd240;
    cycles(3);
    check("no overflow when disabled", 64'(overflow), 64'd0);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
